gbc_hdma: RTL

- CGB VRAM DMA controller (FF51–FF55). Copies 16-byte blocks from the CPU bus (ROM/WRAM/cart RAM) into the 8 KB VRAM window.
- Two modes:
  - General-purpose DMA (GDMA): the whole transfer runs at once.
  - HBlank DMA (HDMA): one block per LCD mode-0 entry.
- Sits beside the video block. Owns the VRAM write port while active and stalls the CPU via `hdma_busy`.

---
 rtl/gbc_hdma.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/gbc_hdma.sv
// CGB VRAM DMA controller (FF51-FF55): general-purpose and HBlank-paced copies of
// 16-byte blocks from the CPU bus into the 8 KB VRAM window.
module gbc_hdma #(
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned DST_WIDTH   = 13
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 cpu_sel_reg,
  input  logic [7:0]           cpu_addr,
  input  logic                 cpu_wr,
  input  logic [7:0]           cpu_di,
  output logic [7:0]           cpu_do,
  input  logic                 lcd_on,
  input  logic [1:0]           lcd_mode,
  output logic                 hdma_busy,
  output logic [15:0]          src_addr,
  output logic                 src_rd,
  input  logic [7:0]           src_data,
  output logic [DST_WIDTH-1:0] vram_addr,
  output logic                 vram_wren,
  output logic [7:0]           vram_di
);

  localparam int unsigned CntW   = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [7:0]  LoMask = 8'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StRd, StWr, StHdmaWait, StHdmaHold} state_e;

  state_e               state_q;
  logic [15:0]          src_q;
  logic [DST_WIDTH-1:0] dst_q;
  logic [6:0]           len_q;
  logic                 hdma_q;
  logic                 stop_pend_q;
  logic [CntW-1:0]      cnt_q;
  logic [1:0]           mode_prev_q;

  logic reg_wr, wr55, stop_req, hblank_edge;

  assign reg_wr      = cpu_sel_reg & cpu_wr;
  assign wr55        = reg_wr & (cpu_addr == 8'h55);
  // Only an HDMA can be cancelled; bit7=1 writes while busy are dropped.
  assign stop_req    = wr55 & hdma_q & ~cpu_di[7] & (state_q != StIdle);
  assign hblank_edge = lcd_on & (mode_prev_q != 2'd0) & (lcd_mode == 2'd0);

  assign src_addr  = src_q;
  assign vram_addr = dst_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= 7'h7F;
      hdma_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      cnt_q       <= '0;
      mode_prev_q <= 2'd0;
      hdma_busy   <= 1'b0;
      src_rd      <= 1'b0;
      vram_wren   <= 1'b0;
      vram_di     <= 8'h00;
    end else if (ce) begin
      mode_prev_q <= lcd_mode;
      src_rd      <= 1'b0;
      vram_wren   <= 1'b0;
      hdma_busy   <= 1'b0;

      if (reg_wr && state_q == StIdle) begin
        case (cpu_addr)
          8'h51: src_q[15:8] <= cpu_di;
          8'h52: src_q[7:0] <= cpu_di & ~LoMask;
          8'h53: dst_q[DST_WIDTH-1:8] <= cpu_di[DST_WIDTH-9:0];
          8'h54: dst_q[7:0] <= cpu_di & ~LoMask;
          default: ;
        endcase
      end

      unique case (state_q)
        StIdle: begin
          if (wr55) begin
            len_q       <= cpu_di[6:0];
            hdma_q      <= cpu_di[7];
            stop_pend_q <= 1'b0;
            cnt_q       <= '0;
            // With the LCD off there are no HBlanks, so the first block goes out now.
            if (!cpu_di[7] || !lcd_on) begin
              state_q   <= StRd;
              src_rd    <= 1'b1;
              hdma_busy <= 1'b1;
            end else begin
              state_q <= StHdmaWait;
            end
          end
        end
        StRd: begin
          state_q   <= StWr;
          vram_wren <= 1'b1;
          vram_di   <= src_data;
          hdma_busy <= 1'b1;
          if (stop_req) stop_pend_q <= 1'b1;
        end
        StWr: begin
          src_q <= src_q + 16'd1;
          dst_q <= dst_q + DST_WIDTH'(1);
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q != CntW'(BLOCK_BYTES - 1)) begin
            state_q   <= StRd;
            src_rd    <= 1'b1;
            hdma_busy <= 1'b1;
            if (stop_req) stop_pend_q <= 1'b1;
          end else if (len_q == 7'd0) begin
            state_q <= StIdle;
            len_q   <= 7'h7F;
          end else begin
            len_q <= len_q - 7'd1;
            if (!hdma_q) begin
              state_q   <= StRd;
              src_rd    <= 1'b1;
              hdma_busy <= 1'b1;
            end else if (stop_pend_q || stop_req) begin
              state_q <= StIdle;
            end else begin
              state_q <= StHdmaHold;
            end
          end
        end
        StHdmaWait: begin
          if (stop_req) begin
            state_q <= StIdle;
          end else if (hblank_edge) begin
            state_q   <= StRd;
            src_rd    <= 1'b1;
            hdma_busy <= 1'b1;
          end
        end
        StHdmaHold: begin
          // Leave mode 0 before re-arming so one HBlank never yields two blocks.
          if (stop_req) begin
            state_q <= StIdle;
          end else if (lcd_mode != 2'd0) begin
            state_q <= StHdmaWait;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    cpu_do = 8'hFF;
    if (cpu_sel_reg && cpu_addr == 8'h55) cpu_do = {state_q == StIdle, len_q};
  end

endmodule
